// File: rtl/result_serializer.sv
// result_serializer
//   Takes one 32-bit ALU result word over a valid/ready handshake and sends it
//   as four bytes on a valid/ready byte stream toward the UART transmitter.
//   It also keeps a wrapping count of words whose four bytes have all been sent.
//
// Parameters
//   MSB_FIRST     1: byte order [31:24],[23:16],[15:8],[7:0]; 0: reversed
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   word_i        result word, sampled only on the word handshake
//   word_valid_i  word_i valid
//   word_ready_o  block can accept a word (high only in IDLE)
//   byte_o        current byte toward UART TX
//   byte_valid_o  byte_o valid (high throughout SEND)
//   byte_ready_i  UART TX accepts byte_o
//   busy_o        a word is in flight
//   words_sent_o  wrapping count of fully sent words
module result_serializer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        busy_o,
    output logic [15:0] words_sent_o
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      state;
    logic [31:0] word_q;
    logic [1:0]  idx;
    logic [15:0] word_cnt;
    logic        word_ready_q;
    logic        byte_valid_q;
    logic        busy_q;
    logic [7:0]  byte_q;

    // Byte lane for send position i. With MSB first, position i maps to lane
    // 3-i, which for a 2-bit index is its bitwise inverse.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
        logic [1:0] lane;
        lane = MSB_FIRST ? ~i : i;
        case (lane)
            2'd0:    pick_byte = w[7:0];
            2'd1:    pick_byte = w[15:8];
            2'd2:    pick_byte = w[23:16];
            default: pick_byte = w[31:24];
        endcase
    endfunction

    // The byte register is loaded one cycle ahead: the first byte at capture
    // and each following byte on the handshake of the byte before it. That
    // keeps byte_o registered and stable under back-pressure. After the last
    // byte it simply holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            word_q       <= '0;
            idx          <= '0;
            word_cnt     <= '0;
            word_ready_q <= 1'b1;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            byte_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (word_valid_i) begin
                        word_q       <= word_i;
                        idx          <= '0;
                        byte_q       <= pick_byte(word_i, 2'd0);
                        state        <= SEND;
                        word_ready_q <= 1'b0;
                        byte_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                SEND: begin
                    if (byte_ready_i) begin
                        if (idx == 2'd3) begin
                            state        <= IDLE;
                            word_cnt     <= word_cnt + 16'd1;
                            word_ready_q <= 1'b1;
                            byte_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end else begin
                            idx    <= idx + 2'd1;
                            byte_q <= pick_byte(word_q, idx + 2'd1);
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    word_ready_q <= 1'b1;
                    byte_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready_o = word_ready_q;
    assign byte_valid_o = byte_valid_q;
    assign busy_o       = busy_q;
    assign byte_o       = byte_q;
    assign words_sent_o = word_cnt;

endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer
//   Drives an MSB-first and an LSB-first result_serializer from the same
//   inputs. Directed table entries and hand-written sequences cover ordering,
//   back-pressure, back-to-back words, counter wrap and mid-word reset. A
//   randomized phase then compares both instances against a byte-queue model.
module tb_result_serializer;

    logic        clk;
    logic        rst_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        byte_ready;

    logic        m_ready, m_valid, m_busy;
    logic [7:0]  m_byte;
    logic [15:0] m_cnt;
    logic        l_ready, l_valid, l_busy;
    logic [7:0]  l_byte;
    logic [15:0] l_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt_m  = '0;
    logic [15:0] cnt_l  = '0;

    result_serializer #(.MSB_FIRST(1'b1)) dut_m (
        .clk_i(clk), .rst_ni(rst_n), .word_i(word_in), .word_valid_i(word_valid),
        .word_ready_o(m_ready), .byte_o(m_byte), .byte_valid_o(m_valid),
        .byte_ready_i(byte_ready), .busy_o(m_busy), .words_sent_o(m_cnt)
    );

    result_serializer #(.MSB_FIRST(1'b0)) dut_l (
        .clk_i(clk), .rst_ni(rst_n), .word_i(word_in), .word_valid_i(word_valid),
        .word_ready_o(l_ready), .byte_o(l_byte), .byte_valid_o(l_valid),
        .byte_ready_i(byte_ready), .busy_o(l_busy), .words_sent_o(l_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " m_ready"}, 32'(m_ready), 32'd1);
        chk({nm, " m_valid"}, 32'(m_valid), 32'd0);
        chk({nm, " m_busy"},  32'(m_busy),  32'd0);
        chk({nm, " m_cnt"},   32'(m_cnt),   32'(cnt_m));
        chk({nm, " l_ready"}, 32'(l_ready), 32'd1);
        chk({nm, " l_valid"}, 32'(l_valid), 32'd0);
        chk({nm, " l_busy"},  32'(l_busy),  32'd0);
        chk({nm, " l_cnt"},   32'(l_cnt),   32'(cnt_l));
    endtask

    // seq_m / seq_l hold the expected byte sequence, first byte in [31:24].
    // The word is driven to 0 once accepted to show later word_i changes are ignored.
    task automatic send_word(input string nm, input logic [31:0] w, input int stall,
                             input logic [31:0] seq_m, input logic [31:0] seq_l);
        logic [7:0] em, el;
        word_in    = w;
        word_valid = 1'b1;
        byte_ready = 1'b1;
        chk({nm, " accept ready"}, 32'({m_ready, l_ready}), 32'd3);
        tick();
        word_valid = 1'b0;
        word_in    = '0;
        for (int i = 0; i < 4; i++) begin
            em = seq_m[31 - 8*i -: 8];
            el = seq_l[31 - 8*i -: 8];
            for (int s = 0; s <= stall; s++) begin
                byte_ready = (s == stall);
                chk({nm, " valid"}, 32'({m_valid, l_valid, m_busy, l_busy, m_ready, l_ready}),
                    32'b111100);
                chk({nm, " m_byte"}, 32'(m_byte), 32'(em));
                chk({nm, " l_byte"}, 32'(l_byte), 32'(el));
                tick();
            end
        end
        cnt_m++;
        cnt_l++;
        chk_idle({nm, " done"});
    endtask

    typedef struct {
        logic [31:0] word;
        int          stall;
        logic [31:0] seq_m;
        logic [31:0] seq_l;
    } vec_t;

    vec_t vecs[4];

    // Higher-level reference: pending bytes per instance as queues.
    logic [7:0] qm[$];
    logic [7:0] ql[$];

    initial begin
        int         hs[3];
        int         k;
        logic [7:0] got_m[$];
        logic [7:0] got_l[$];
        logic [31:0] w;
        logic        v, r;

        vecs[0] = '{32'hDEADBEEF, 0, 32'hDEADBEEF, 32'hEFBEADDE};
        vecs[1] = '{32'h12345678, 0, 32'h12345678, 32'h78563412};
        vecs[2] = '{32'hA1B2C3D4, 3, 32'hA1B2C3D4, 32'hD4C3B2A1};
        vecs[3] = '{32'h00FF8001, 1, 32'h00FF8001, 32'h0180FF00};

        rst_n = 1'b0; word_in = '0; word_valid = 1'b0; byte_ready = 1'b0;
        repeat (3) tick();
        chk("reset byte_m", 32'(m_byte), 32'h0);
        chk("reset byte_l", 32'(l_byte), 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk_idle("reset idle");
            tick();
        end

        for (int i = 0; i < 4; i++)
            send_word($sformatf("vec%0d", i), vecs[i].word, vecs[i].stall,
                      vecs[i].seq_m, vecs[i].seq_l);

        // Back-to-back: word_valid held high, words 1,2,3.
        byte_ready = 1'b1;
        word_valid = 1'b1;
        k = 0;
        word_in = 32'd1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (m_valid) got_m.push_back(m_byte);
            if (l_valid) got_l.push_back(l_byte);
            if (k < 3 && m_ready && word_valid) begin
                hs[k] = cyc;
                k++;
            end
            tick();
            word_in    = 32'(k + 1);
            word_valid = (k < 3);
            if (k == 3 && got_m.size() >= 12 && m_ready) break;
        end
        chk("b2b accepted", 32'(k), 32'd3);
        if (k == 3) begin
            chk("b2b spacing1", 32'(hs[1] - hs[0]), 32'd5);
            chk("b2b spacing2", 32'(hs[2] - hs[1]), 32'd5);
        end
        chk("b2b nbytes_m", 32'(got_m.size()), 32'd12);
        chk("b2b nbytes_l", 32'(got_l.size()), 32'd12);
        if (got_m.size() == 12 && got_l.size() == 12) begin
            for (int n = 0; n < 3; n++)
                for (int j = 0; j < 4; j++) begin
                    chk("b2b byte_m", 32'(got_m[4*n + j]), (j == 3) ? 32'(n + 1) : 32'd0);
                    chk("b2b byte_l", 32'(got_l[4*n + j]), (j == 0) ? 32'(n + 1) : 32'd0);
                end
        end
        cnt_m += 16'd3;
        cnt_l += 16'd3;
        chk_idle("b2b end");

        // Counter wrap: preload the MSB instance's counter to 16'hFFFF.
        force dut_m.word_cnt = 16'hFFFF;
        #1;
        release dut_m.word_cnt;
        cnt_m = 16'hFFFF;
        chk("wrap preload", 32'(m_cnt), 32'h0000FFFF);
        send_word("wrap", 32'h01020304, 0, 32'h01020304, 32'h04030201);
        chk("wrap zero", 32'(m_cnt), 32'h0);

        // Reset mid-word after the second byte is accepted.
        word_in = 32'hCAFEF00D; word_valid = 1'b1; byte_ready = 1'b1;
        tick();
        word_valid = 1'b0;
        chk("mid byte1", 32'(m_byte), 32'hCA);
        tick();
        chk("mid byte2", 32'(m_byte), 32'hFE);
        tick();
        chk("mid byte3 up", 32'(m_byte), 32'hF0);
        rst_n = 1'b0;
        #1;
        cnt_m = '0;
        cnt_l = '0;
        chk_idle("mid reset");
        chk("mid reset byte", 32'(m_byte), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("mid release");
        send_word("after reset", 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'hEFBEADDE);

        // Randomized phase against the queue model.
        for (int cyc = 0; cyc < 800; cyc++) begin
            chk("rnd m_valid", 32'(m_valid), 32'(qm.size() != 0));
            chk("rnd m_ready", 32'(m_ready), 32'(qm.size() == 0));
            chk("rnd m_busy",  32'(m_busy),  32'(qm.size() != 0));
            chk("rnd l_valid", 32'(l_valid), 32'(ql.size() != 0));
            chk("rnd l_ready", 32'(l_ready), 32'(ql.size() == 0));
            if (qm.size() != 0) chk("rnd m_byte", 32'(m_byte), 32'(qm[0]));
            if (ql.size() != 0) chk("rnd l_byte", 32'(l_byte), 32'(ql[0]));
            chk("rnd m_cnt", 32'(m_cnt), 32'(cnt_m));
            chk("rnd l_cnt", 32'(l_cnt), 32'(cnt_l));
            w = $urandom;
            v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 3) != 0);
            word_in = w; word_valid = v; byte_ready = r;
            tick();
            if (qm.size() == 0) begin
                if (v) begin
                    for (int j = 0; j < 4; j++) begin
                        qm.push_back(w[31 - 8*j -: 8]);
                        ql.push_back(w[8*j +: 8]);
                    end
                end
            end else if (r) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
                if (qm.size() == 0) begin
                    cnt_m++;
                    cnt_l++;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
